// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state encoding and derived widths for the instruction cache
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MISS = 2'b01,
    FILL = 2'b10
  } icache_state_t;

  function automatic int tag_width(input int address_size, input int c_index_size,
                                   input int c_block_size);
    return address_size - c_index_size - c_block_size - 2;
  endfunction

  function automatic int block_width(input int c_block_size, input int c_line_size);
    return (2 ** c_block_size) * c_line_size;
  endfunction

  function automatic int mem_addr_width(input int address_size, input int c_block_size);
    return address_size - c_block_size - 2;
  endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - CPU fetch port and block-read memory port bundles
interface icache_cpu_if #(
  parameter int address_size = 32,
  parameter int c_line_size  = 32
);
  logic                    c_read_i;
  logic [address_size-1:0] c_addr_i;
  logic                    c_flush_i;
  logic [c_line_size-1:0]  c_instr_o;
  logic                    c_busywait_o;

  modport master (output c_read_i, c_addr_i, c_flush_i, input c_instr_o, c_busywait_o);
  modport slave  (input c_read_i, c_addr_i, c_flush_i, output c_instr_o, c_busywait_o);
endinterface

interface icache_mem_if #(
  parameter int mem_addr_size = 28,
  parameter int block_bits    = 128
);
  logic                     mem_read_o;
  logic [mem_addr_size-1:0] mem_addr_o;
  logic [block_bits-1:0]    mem_data_i;
  logic                     mem_busywait_i;
  logic                     mem_read_done_i;

  modport master (output mem_read_o, mem_addr_o,
                  input mem_data_i, mem_busywait_i, mem_read_done_i);
  modport slave  (input mem_read_o, mem_addr_o,
                  output mem_data_i, mem_busywait_i, mem_read_done_i);
endinterface

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays with one write port and a combinational read port
module icache_line_store #(
  parameter int index_size = 3,
  parameter int tag_size   = 25,
  parameter int block_bits = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_all,
  input  logic                  wr_en,
  input  logic [index_size-1:0] wr_index,
  input  logic [tag_size-1:0]   wr_tag,
  input  logic [block_bits-1:0] wr_block,
  input  logic [index_size-1:0] rd_index,
  output logic                  rd_valid,
  output logic [tag_size-1:0]   rd_tag,
  output logic [block_bits-1:0] rd_block
);

  localparam int num_lines = 2 ** index_size;

  logic [num_lines-1:0]  valid;
  logic [tag_size-1:0]   tags  [num_lines];
  logic [block_bits-1:0] data  [num_lines];

  // Only the valid bits need reset; stale tag/data behind a clear valid bit is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_block;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_block = data[rd_index];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with zero-wait hits and whole-block refill
module icache
  import icache_pkg::*;
#(
  parameter int c_block_size = 2,
  parameter int c_line_size  = 32,
  parameter int address_size = 32,
  parameter int c_index_size = 3
) (
  input logic         c_clk_i,
  input logic         c_reset_n_i,
  icache_cpu_if.slave cpu,
  icache_mem_if.master mem
);

  localparam int tag_size      = tag_width(address_size, c_index_size, c_block_size);
  localparam int block_bits    = block_width(c_block_size, c_line_size);
  localparam int mem_addr_size = mem_addr_width(address_size, c_block_size);
  localparam int words         = 2 ** c_block_size;

  icache_state_t state;
  logic          flush_pending;
  logic [tag_size-1:0]      miss_tag;
  logic [c_index_size-1:0]  miss_index;
  logic                     mem_read_r;
  logic [mem_addr_size-1:0] mem_addr_r;

  logic [c_block_size-1:0] addr_offset;
  logic [c_index_size-1:0] addr_index;
  logic [tag_size-1:0]     addr_tag;

  logic                  rd_valid;
  logic [tag_size-1:0]   rd_tag;
  logic [block_bits-1:0] rd_block;
  logic [c_line_size-1:0] rd_words [words];

  logic hit;
  logic wr_en;
  logic flush_all;
  logic [2:0] unused_inputs;

  assign addr_offset = cpu.c_addr_i[c_block_size+1:2];
  assign addr_index  = cpu.c_addr_i[c_block_size+2 +: c_index_size];
  assign addr_tag    = cpu.c_addr_i[address_size-1 -: tag_size];

  assign unused_inputs = {mem.mem_busywait_i, cpu.c_addr_i[1:0]};

  for (genvar k = 0; k < words; k++) begin : g_word
    assign rd_words[k] = rd_block[k*c_line_size +: c_line_size];
  end

  assign hit = cpu.c_read_i && rd_valid && (rd_tag == addr_tag)
            && (state == IDLE) && !cpu.c_flush_i;

  assign cpu.c_instr_o    = hit ? rd_words[addr_offset] : '0;
  assign cpu.c_busywait_o = cpu.c_read_i && !hit;

  assign wr_en = (state == MISS) && mem.mem_read_done_i;

  // A flush seen during a refill is deferred so the in-flight block still lands, then is discarded.
  assign flush_all = ((state == IDLE) && cpu.c_flush_i)
                  || ((state == FILL) && (flush_pending || cpu.c_flush_i));

  icache_line_store #(
    .index_size (c_index_size),
    .tag_size   (tag_size),
    .block_bits (block_bits)
  ) u_line_store (
    .clk       (c_clk_i),
    .rst_n     (c_reset_n_i),
    .flush_all (flush_all),
    .wr_en     (wr_en),
    .wr_index  (miss_index),
    .wr_tag    (miss_tag),
    .wr_block  (mem.mem_data_i),
    .rd_index  (addr_index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_block  (rd_block)
  );

  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      miss_tag      <= '0;
      miss_index    <= '0;
      mem_read_r    <= 1'b0;
      mem_addr_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cpu.c_flush_i && cpu.c_read_i && !hit) begin
            miss_tag   <= addr_tag;
            miss_index <= addr_index;
            mem_read_r <= 1'b1;
            mem_addr_r <= {addr_tag, addr_index};
            state      <= MISS;
          end
        end
        MISS: begin
          if (cpu.c_flush_i) begin
            flush_pending <= 1'b1;
          end
          if (mem.mem_read_done_i) begin
            mem_read_r <= 1'b0;
            mem_addr_r <= '0;
            state      <= FILL;
          end
        end
        FILL: begin
          flush_pending <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          mem_read_r <= 1'b0;
          mem_addr_r <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_read_o = mem_read_r;
  assign mem.mem_addr_o = mem_addr_r;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for the instruction cache
module tb_icache;

  logic clk;
  logic rst_n;
  logic spurious_done;
  int   checks;
  int   errors;
  int   req_count;
  logic [27:0] last_req_addr;
  logic prev_rd;
  int   mem_cnt;

  icache_cpu_if cpu_if ();
  icache_mem_if mem_if ();

  icache dut (
    .c_clk_i     (clk),
    .c_reset_n_i (rst_n),
    .cpu         (cpu_if.slave),
    .mem         (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] block_for(input logic [27:0] a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = {2'b00, a, 2'(k)};
    return r;
  endfunction

  // Memory model: done asserted once mem_read_o has been seen for five edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_cnt <= 0;
    else if (!mem_if.mem_read_o) mem_cnt <= 0;
    else if (mem_cnt < 5) mem_cnt <= mem_cnt + 1;
  end

  assign mem_if.mem_read_done_i = (mem_if.mem_read_o && mem_cnt == 5) || spurious_done;
  assign mem_if.mem_data_i      = block_for(mem_if.mem_addr_o);
  assign mem_if.mem_busywait_i  = mem_if.mem_read_o;

  initial begin
    req_count = 0;
    prev_rd   = 1'b0;
    last_req_addr = '0;
  end

  always @(negedge clk) begin
    if (mem_if.mem_read_o && !prev_rd) begin
      req_count++;
      last_req_addr = mem_if.mem_addr_o;
    end
    prev_rd = mem_if.mem_read_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (cpu_if.c_busywait_o === 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_if.c_read_i = 1'b0; cpu_if.c_addr_i = 32'h40; cpu_if.c_flush_i = 1'b0;
    spurious_done = 1'b0;
    tick(); tick();
    checks++; if (mem_if.mem_read_o !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_if.mem_read_o); end
    checks++; if (mem_if.mem_addr_o !== 28'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_if.mem_addr_o); end
    checks++; if (cpu_if.c_busywait_o !== 1'b0) begin errors++; $display("FAIL reset_busy_idle: got %b expected 0", cpu_if.c_busywait_o); end
    cpu_if.c_read_i = 1'b1; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1) begin errors++; $display("FAIL reset_busy_read: got %b expected 1", cpu_if.c_busywait_o); end
    checks++; if (cpu_if.c_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", cpu_if.c_instr_o); end
    cpu_if.c_read_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    int n;
    int req0;
    logic [31:0] exp;
    cpu_if.c_read_i = 1'b1; cpu_if.c_addr_i = 32'h40; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1) begin errors++; $display("FAIL cold_busy: got %b expected 1", cpu_if.c_busywait_o); end
    tick();
    checks++; if (mem_if.mem_read_o !== 1'b1) begin errors++; $display("FAIL cold_mem_read: got %b expected 1", mem_if.mem_read_o); end
    checks++; if (mem_if.mem_addr_o !== 28'h004) begin errors++; $display("FAIL cold_mem_addr: got %h expected 004", mem_if.mem_addr_o); end
    wait_idle(50, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL cold_penalty: got %0d expected 7", n); end
    checks++; if (cpu_if.c_instr_o !== 32'h10) begin errors++; $display("FAIL cold_instr: got %h expected 10", cpu_if.c_instr_o); end
    req0 = req_count;
    for (int i = 1; i < 4; i++) begin
      cpu_if.c_addr_i = 32'h40 + 32'(4*i); exp = 32'h10 + 32'(i); #1;
      checks++; if (cpu_if.c_busywait_o !== 1'b0 || cpu_if.c_instr_o !== exp) begin
        errors++; $display("FAIL hit_word%0d: got busy=%b instr=%h expected busy=0 instr=%h", i, cpu_if.c_busywait_o, cpu_if.c_instr_o, exp);
      end
      tick();
    end
    checks++; if (mem_if.mem_read_o !== 1'b0 || req_count !== req0) begin
      errors++; $display("FAIL hit_no_request: got mem_read=%b new_reqs=%0d expected 0/0", mem_if.mem_read_o, req_count - req0);
    end
  endtask

  task automatic test_conflict();
    int n;
    cpu_if.c_addr_i = 32'hC0; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1) begin errors++; $display("FAIL conflict_busy: got %b expected 1", cpu_if.c_busywait_o); end
    tick();
    checks++; if (mem_if.mem_addr_o !== 28'h00C) begin errors++; $display("FAIL conflict_addr: got %h expected 00c", mem_if.mem_addr_o); end
    wait_idle(50, n);
    checks++; if (cpu_if.c_instr_o !== 32'h30) begin errors++; $display("FAIL conflict_instr: got %h expected 30", cpu_if.c_instr_o); end
    cpu_if.c_addr_i = 32'h40; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1) begin errors++; $display("FAIL refetch_busy: got %b expected 1", cpu_if.c_busywait_o); end
    tick();
    checks++; if (mem_if.mem_addr_o !== 28'h004) begin errors++; $display("FAIL refetch_addr: got %h expected 004", mem_if.mem_addr_o); end
    wait_idle(50, n);
    checks++; if (cpu_if.c_instr_o !== 32'h10) begin errors++; $display("FAIL refetch_instr: got %h expected 10", cpu_if.c_instr_o); end
  endtask

  task automatic test_flush_idle();
    int n;
    cpu_if.c_read_i = 1'b0; cpu_if.c_flush_i = 1'b1;
    tick();
    cpu_if.c_flush_i = 1'b0; cpu_if.c_read_i = 1'b1; cpu_if.c_addr_i = 32'h44; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1) begin errors++; $display("FAIL flush_idle_busy: got %b expected 1", cpu_if.c_busywait_o); end
    tick();
    checks++; if (mem_if.mem_read_o !== 1'b1 || mem_if.mem_addr_o !== 28'h004) begin
      errors++; $display("FAIL flush_idle_req: got read=%b addr=%h expected 1/004", mem_if.mem_read_o, mem_if.mem_addr_o);
    end
    wait_idle(50, n);
    checks++; if (cpu_if.c_instr_o !== 32'h11) begin errors++; $display("FAIL flush_idle_instr: got %h expected 11", cpu_if.c_instr_o); end
    // flush coinciding with a fetch: flush wins, the miss is raised a cycle later
    cpu_if.c_addr_i = 32'h48; cpu_if.c_flush_i = 1'b1; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1 || cpu_if.c_instr_o !== 32'h0) begin
      errors++; $display("FAIL flush_wins_comb: got busy=%b instr=%h expected 1/0", cpu_if.c_busywait_o, cpu_if.c_instr_o);
    end
    tick();
    checks++; if (mem_if.mem_read_o !== 1'b0) begin errors++; $display("FAIL flush_wins_no_miss: got %b expected 0", mem_if.mem_read_o); end
    cpu_if.c_flush_i = 1'b0;
    tick();
    checks++; if (mem_if.mem_read_o !== 1'b1 || mem_if.mem_addr_o !== 28'h004) begin
      errors++; $display("FAIL flush_wins_late_miss: got read=%b addr=%h expected 1/004", mem_if.mem_read_o, mem_if.mem_addr_o);
    end
    wait_idle(50, n);
    checks++; if (cpu_if.c_instr_o !== 32'h12) begin errors++; $display("FAIL flush_wins_instr: got %h expected 12", cpu_if.c_instr_o); end
  endtask

  task automatic test_flush_miss();
    int n;
    int req0;
    cpu_if.c_read_i = 1'b0; cpu_if.c_flush_i = 1'b1;
    tick();
    cpu_if.c_flush_i = 1'b0;
    req0 = req_count;
    cpu_if.c_read_i = 1'b1; cpu_if.c_addr_i = 32'h40;
    tick();
    cpu_if.c_flush_i = 1'b1;
    tick();
    cpu_if.c_flush_i = 1'b0;
    wait_idle(80, n);
    checks++; if (n !== 14) begin errors++; $display("FAIL flush_miss_cycles: got %0d expected 14", n); end
    checks++; if (req_count - req0 !== 2 || last_req_addr !== 28'h004) begin
      errors++; $display("FAIL flush_miss_rerequest: got reqs=%0d addr=%h expected 2/004", req_count - req0, last_req_addr);
    end
    checks++; if (cpu_if.c_instr_o !== 32'h10) begin errors++; $display("FAIL flush_miss_instr: got %h expected 10", cpu_if.c_instr_o); end
  endtask

  task automatic test_reset_mid_miss();
    int n;
    cpu_if.c_addr_i = 32'hC0;
    tick();
    checks++; if (mem_if.mem_read_o !== 1'b1 || mem_if.mem_addr_o !== 28'h00C) begin
      errors++; $display("FAIL mid_miss_req: got read=%b addr=%h expected 1/00c", mem_if.mem_read_o, mem_if.mem_addr_o);
    end
    tick(); tick();
    rst_n = 1'b0; #1;
    checks++; if (mem_if.mem_read_o !== 1'b0 || mem_if.mem_addr_o !== 28'h0) begin
      errors++; $display("FAIL mid_miss_abort: got read=%b addr=%h expected 0/0", mem_if.mem_read_o, mem_if.mem_addr_o);
    end
    cpu_if.c_addr_i = 32'h40;
    tick();
    rst_n = 1'b1; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1) begin errors++; $display("FAIL post_reset_busy: got %b expected 1", cpu_if.c_busywait_o); end
    tick();
    checks++; if (mem_if.mem_read_o !== 1'b1 || mem_if.mem_addr_o !== 28'h004) begin
      errors++; $display("FAIL post_reset_req: got read=%b addr=%h expected 1/004", mem_if.mem_read_o, mem_if.mem_addr_o);
    end
    wait_idle(50, n);
    checks++; if (n !== 7 || cpu_if.c_instr_o !== 32'h10) begin
      errors++; $display("FAIL post_reset_fill: got cycles=%0d instr=%h expected 7/10", n, cpu_if.c_instr_o);
    end
  endtask

  task automatic test_no_read();
    int n;
    cpu_if.c_read_i = 1'b0; cpu_if.c_addr_i = 32'h1234_5678; spurious_done = 1'b1; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b0 || cpu_if.c_instr_o !== 32'h0) begin
      errors++; $display("FAIL no_read_comb: got busy=%b instr=%h expected 0/0", cpu_if.c_busywait_o, cpu_if.c_instr_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_if.mem_read_o !== 1'b0) begin errors++; $display("FAIL spurious_done_read%0d: got %b expected 0", i, mem_if.mem_read_o); end
    end
    spurious_done = 1'b0;
    cpu_if.c_read_i = 1'b1; cpu_if.c_addr_i = 32'h0C; #1;
    checks++; if (cpu_if.c_busywait_o !== 1'b1) begin errors++; $display("FAIL spurious_no_write: got busy=%b expected 1", cpu_if.c_busywait_o); end
    tick();
    checks++; if (mem_if.mem_read_o !== 1'b1 || mem_if.mem_addr_o !== 28'h000) begin
      errors++; $display("FAIL index0_req: got read=%b addr=%h expected 1/000", mem_if.mem_read_o, mem_if.mem_addr_o);
    end
    wait_idle(50, n);
    checks++; if (cpu_if.c_instr_o !== 32'h3) begin errors++; $display("FAIL index0_instr: got %h expected 3", cpu_if.c_instr_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_flush_idle();
    test_flush_miss();
    test_reset_mid_miss();
    test_no_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
